// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit accumulator CPU: instruction opcodes,
// ALU operation codes and the sequencer phase encoding.
package cpu_pkg;

    typedef enum logic [2:0] {
        HLT = 3'd0,
        SKZ = 3'd1,
        ADD = 3'd2,
        AND = 3'd3,
        XOR = 3'd4,
        LDA = 3'd5,
        STO = 3'd6,
        JMP = 3'd7
    } opcode_t;

    typedef enum logic [1:0] {
        ALU_ADD  = 2'd0,
        ALU_AND  = 2'd1,
        ALU_XOR  = 2'd2,
        ALU_PASS = 2'd3
    } alu_op_t;

    // Phases 0-7 form the instruction cycle; HALTED sits outside the ring.
    typedef enum logic [3:0] {
        INST_ADDR  = 4'd0,
        INST_FETCH = 4'd1,
        INST_LOAD  = 4'd2,
        IDLE       = 4'd3,
        OP_ADDR    = 4'd4,
        OP_FETCH   = 4'd5,
        ALU_OP     = 4'd6,
        STORE      = 4'd7,
        HALTED     = 4'd8
    } phase_t;

    // Instructions whose result comes back from the ALU into the accumulator.
    function automatic logic is_aluop(opcode_t op);
        return (op == ADD) || (op == AND) || (op == XOR) || (op == LDA);
    endfunction

endpackage

// File: rtl/seq_controller.sv
// Phase sequencer for the accumulator CPU: an eight-phase instruction ring
// plus a sticky HALTED state, with outputs decoded from phase and opcode.
module seq_controller
    import cpu_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] opcode,
    input  logic       zero,
    output logic       sel,
    output logic       rd,
    output logic       ld_ir,
    output logic       halt,
    output logic       inc_pc,
    output logic       ld_ac,
    output logic       ld_pc,
    output logic       wr,
    output logic       data_e,
    output phase_t     phase
);

    phase_t  phase_next;
    opcode_t op;
    logic    aluop;

    assign op    = opcode_t'(opcode);
    assign aluop = is_aluop(op);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase <= INST_ADDR;
        end else begin
            phase <= phase_next;
        end
    end

    always_comb begin
        phase_next = phase;
        sel        = 1'b0;
        rd         = 1'b0;
        ld_ir      = 1'b0;
        halt       = 1'b0;
        inc_pc     = 1'b0;
        ld_ac      = 1'b0;
        ld_pc      = 1'b0;
        wr         = 1'b0;
        data_e     = 1'b0;

        case (phase)
            INST_ADDR: begin
                sel        = 1'b1;
                phase_next = INST_FETCH;
            end
            INST_FETCH: begin
                sel        = 1'b1;
                rd         = 1'b1;
                phase_next = INST_LOAD;
            end
            INST_LOAD: begin
                sel        = 1'b1;
                rd         = 1'b1;
                ld_ir      = 1'b1;
                phase_next = IDLE;
            end
            IDLE: begin
                sel        = 1'b1;
                rd         = 1'b1;
                ld_ir      = 1'b1;
                phase_next = OP_ADDR;
            end
            OP_ADDR: begin
                inc_pc = 1'b1;
                if (op == HLT) begin
                    halt       = 1'b1;
                    phase_next = HALTED;
                end else begin
                    phase_next = OP_FETCH;
                end
            end
            OP_FETCH: begin
                rd         = aluop;
                phase_next = ALU_OP;
            end
            ALU_OP: begin
                // zero is only consulted here, to skip the next instruction.
                rd         = aluop;
                inc_pc     = (op == SKZ) && zero;
                ld_pc      = (op == JMP);
                data_e     = (op == STO);
                phase_next = STORE;
            end
            STORE: begin
                rd         = aluop;
                ld_ac      = aluop;
                inc_pc     = (op == JMP);
                ld_pc      = (op == JMP);
                wr         = (op == STO);
                data_e     = (op == STO);
                phase_next = INST_ADDR;
            end
            HALTED: begin
                halt       = 1'b1;
                phase_next = HALTED;
            end
            default: begin
                phase_next = INST_ADDR;
            end
        endcase
    end

endmodule

// File: tb/tb_seq_controller.sv
// Bench for seq_controller: per-phase output vectors are predicted from the
// instruction table and compared through a scoreboard queue.
module tb_seq_controller;
    import cpu_pkg::*;

    logic       clk;
    logic       rst;
    logic [2:0] opcode;
    logic       zero;
    logic       sel, rd, ld_ir, halt, inc_pc, ld_ac, ld_pc, wr, data_e;
    phase_t     phase;

    int n_checks = 0;
    int n_errors = 0;

    // Vector order: {sel, rd, ld_ir, halt, inc_pc, ld_ac, ld_pc, wr, data_e}
    logic [8:0] exp_q[$];
    logic [3:0] exp_ph_q[$];

    seq_controller dut (
        .clk    (clk),
        .rst    (rst),
        .opcode (opcode),
        .zero   (zero),
        .sel    (sel),
        .rd     (rd),
        .ld_ir  (ld_ir),
        .halt   (halt),
        .inc_pc (inc_pc),
        .ld_ac  (ld_ac),
        .ld_pc  (ld_pc),
        .wr     (wr),
        .data_e (data_e),
        .phase  (phase)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Expected outputs per phase index (0-7 ring, 8 = halted), column by column.
    function automatic logic [8:0] model(input int ph, input logic [2:0] op, input logic z);
        logic alu, e_sel, e_rd, e_ir, e_halt, e_inc, e_ac, e_pc, e_wr, e_de;
        alu    = (op >= 3'd2) && (op <= 3'd5);
        e_sel  = (ph <= 3);
        e_rd   = (ph >= 1 && ph <= 3) || (ph >= 5 && ph <= 7 && alu);
        e_ir   = (ph == 2) || (ph == 3);
        e_halt = (ph == 8) || (ph == 4 && op == 3'd0);
        e_inc  = (ph == 4) || (ph == 6 && op == 3'd1 && z) || (ph == 7 && op == 3'd7);
        e_ac   = (ph == 7) && alu;
        e_pc   = (ph == 6 || ph == 7) && op == 3'd7;
        e_wr   = (ph == 7) && op == 3'd6;
        e_de   = (ph == 6 || ph == 7) && op == 3'd6;
        return {e_sel, e_rd, e_ir, e_halt, e_inc, e_ac, e_pc, e_wr, e_de};
    endfunction

    function automatic logic [8:0] dut_vec();
        return {sel, rd, ld_ir, halt, inc_pc, ld_ac, ld_pc, wr, data_e};
    endfunction

    task automatic compare_head(input string tag);
        logic [8:0] e;
        logic [3:0] ep;
        e  = exp_q.pop_front();
        ep = exp_ph_q.pop_front();
        check_eq({tag, "_out"}, 32'(dut_vec()), 32'(e));
        check_eq({tag, "_phase"}, 32'(phase), 32'(ep));
    endtask

    // Called just after a rising edge; leaves time just after the next one.
    task automatic drive_phase(input logic [2:0] op, input logic z, input int ph, input string tag);
        opcode = op;
        zero   = z;
        exp_q.push_back(model(ph, op, z));
        exp_ph_q.push_back(4'(ph));
        @(negedge clk);
        compare_head(tag);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        #2;
        exp_q.push_back(9'b1_0000_0000);
        exp_ph_q.push_back(4'd0);
        compare_head(tag);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic run_instr(input logic [2:0] op, input logic z, input string tag);
        for (int ph = 0; ph < 8; ph++) begin
            if (ph == 5 && op == 3'd0) begin
                for (int k = 0; k < 20; k++) begin
                    drive_phase(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 8, {tag, "_halted"});
                end
                do_reset({tag, "_rst"});
                return;
            end
            drive_phase(op, z, ph, tag);
        end
    endtask

    initial begin
        rst    = 1'b1;
        opcode = 3'd0;
        zero   = 1'b0;
        #3;
        exp_q.push_back(9'b1_0000_0000);
        exp_ph_q.push_back(4'd0);
        compare_head("reset");
        @(posedge clk);
        #1;
        exp_q.push_back(9'b1_0000_0000);
        exp_ph_q.push_back(4'd0);
        compare_head("reset_held");
        rst = 1'b0;

        run_instr(3'd2, 1'b0, "add");
        run_instr(3'd1, 1'b1, "skz_z1");
        run_instr(3'd1, 1'b0, "skz_z0");
        run_instr(3'd6, 1'b1, "sto");
        run_instr(3'd7, 1'b0, "jmp");
        run_instr(3'd3, 1'b1, "and");
        run_instr(3'd4, 1'b0, "xor");
        run_instr(3'd5, 1'b0, "lda");
        run_instr(3'd0, 1'b0, "hlt");

        // Reset in the middle of an ALU_OP phase must act before the next edge.
        for (int ph = 0; ph < 6; ph++) drive_phase(3'd6, 1'b0, ph, "mid");
        opcode = 3'd6;
        #1;
        exp_q.push_back(model(6, 3'd6, 1'b0));
        exp_ph_q.push_back(4'd6);
        compare_head("mid_aluop");
        rst = 1'b1;
        #1;
        exp_q.push_back(9'b1_0000_0000);
        exp_ph_q.push_back(4'd0);
        compare_head("mid_rst");
        @(posedge clk);
        #1;
        rst = 1'b0;

        for (int i = 0; i < 12; i++) begin
            run_instr(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), "rand");
        end

        check_eq("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
